// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: shared widths, queue entry type and enable constants for the write-back queue
package wb_queue_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH_N = 8;
    localparam int PTR_W = $clog2(DEPTH_N);
    localparam int CNT_W = PTR_W + 1;
    localparam logic ENABLE = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic ENABLE_ = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/wb_queue_compact.sv
// wb_queue_compact: packs valid result ports into consecutive entries, lowest (oldest) port first
module wb_queue_compact
    import wb_queue_pkg::*;
#(
    parameter int IN = 4,
    parameter int DATA = DATA_W,
    parameter int ADDR = ADDR_W,
    parameter logic ZERO_REG = DISABLE
) (
    input  logic [IN-1:0]           valid,
    input  logic [IN-1:0][ADDR-1:0] addr,
    input  logic [IN-1:0][DATA-1:0] data,
    output entry_t [IN-1:0]         ent,
    output logic [$clog2(IN+1)-1:0] num
);
    localparam int NW = $clog2(IN + 1);
    localparam int IW = IN > 1 ? $clog2(IN) : 1;
    always_comb begin
        ent = '0;
        num = '0;
        for (int i = 0; i < IN; i++)
            if (valid[i] && !(ZERO_REG == ENABLE && addr[i] == '0)) begin
                ent[num[IW-1:0]] = '{addr[i], data[i]};
                num = num + NW'(1);
            end
    end
endmodule

// File: rtl/wb_queue.sv
// wb_queue: circular write-back queue draining up to WRITE oldest results per cycle to the register file.
// Defining WB_QUEUE_BYPASS_EN adds combinational lookup ports over the queued entries.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DATA = DATA_W,
    parameter int ADDR = ADDR_W,
    parameter int IN = 4,
    parameter int WRITE = 4,
    parameter int DEPTH = DEPTH_N,
`ifdef WB_QUEUE_BYPASS_EN
    parameter int READ = 4,
`endif
    parameter logic ZERO_REG = DISABLE
) (
    input  logic                       clk,
    input  logic                       reset_,
`ifdef WB_QUEUE_BYPASS_EN
    input  logic [READ-1:0][ADDR-1:0]  byp_raddr,
    output logic [READ-1:0]            byp_hit,
    output logic [READ-1:0][DATA-1:0]  byp_data,
`endif
    input  logic [IN-1:0]              in_valid,
    input  logic [IN-1:0][ADDR-1:0]    in_addr,
    input  logic [IN-1:0][DATA-1:0]    in_data,
    output logic                       in_ready,
    output logic [WRITE-1:0][ADDR-1:0] waddr,
    output logic [WRITE-1:0]           we_,
    output logic [WRITE-1:0][DATA-1:0] wdata,
    output logic [CNT_W-1:0]           count,
    output logic                       empty
);
    localparam int NW = $clog2(IN + 1);
    localparam logic [CNT_W-1:0] ROOM = CNT_W'(DEPTH - IN);
    localparam logic [CNT_W-1:0] WMAX = CNT_W'(WRITE);
    entry_t mem [DEPTH];
    entry_t [IN-1:0] ent;
    entry_t [WRITE-1:0] slot;
    logic [NW-1:0] num;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] enq, drain;

    wb_queue_compact #(.IN(IN), .DATA(DATA), .ADDR(ADDR), .ZERO_REG(ZERO_REG)) u_compact (
        .valid(in_valid), .addr(in_addr), .data(in_data), .ent(ent), .num(num)
    );

    assign in_ready = count <= ROOM;
    assign empty = count == '0;
    assign enq = in_ready ? CNT_W'(num) : '0;
    assign drain = count < WMAX ? count : WMAX;

    always_comb begin
        for (int s = 0; s < WRITE; s++) begin
            slot[s] = mem[head + PTR_W'(s)];
            waddr[s] = slot[s].addr;
            wdata[s] = slot[s].data;
            we_[s] = CNT_W'(s) < drain ? ENABLE_ : DISABLE_;
        end
        // a younger entry to the same register in this group supersedes the older one
        for (int s = 0; s < WRITE; s++)
            for (int t = s + 1; t < WRITE; t++)
                if (CNT_W'(t) < drain && slot[t].addr == slot[s].addr) we_[s] = DISABLE_;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            for (int j = 0; j < IN; j++)
                if (in_ready && NW'(j) < num) mem[tail + PTR_W'(j)] <= ent[j];
            tail <= tail + PTR_W'(enq);
            head <= head + PTR_W'(drain);
            count <= count + enq - drain;
        end
    end

`ifdef WB_QUEUE_BYPASS_EN
    always_comb begin
        byp_hit = '0;
        byp_data = '0;
        for (int r = 0; r < READ; r++)
            for (int k = 0; k < DEPTH; k++)
                if (CNT_W'(k) < count && mem[head + PTR_W'(k)].addr == byp_raddr[r]
                    && !(ZERO_REG == ENABLE && byp_raddr[r] == '0)) begin
                    byp_hit[r] = 1'b1;
                    byp_data[r] = mem[head + PTR_W'(k)].data;
                end
    end
`endif
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: table vectors and a queue scoreboard for wb_queue, with a ZERO_REG-enabled copy alongside
module tb_wb_queue;
    import wb_queue_pkg::*;

    typedef struct {
        logic rst_n;
        logic [3:0] v;
        logic [3:0][3:0] a;
        logic [3:0][31:0] d;
        logic [3:0] cnt;
        logic [3:0] we;
        logic [3:0] zcnt;
        logic [3:0] zwe;
    } vec_t;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    logic [3:0] in_valid = '0;
    logic [3:0][3:0] in_addr = '0;
    logic [3:0][31:0] in_data = '0;
    logic rdy0, rdy1, emp0, emp1;
    logic [3:0] we0, we1, cnt0, cnt1;
    logic [3:0][3:0] wa0, wa1;
    logic [3:0][31:0] wd0, wd1;
`ifdef WB_QUEUE_BYPASS_EN
    logic [3:0][3:0] byp_raddr = '0;
    logic [3:0] hit0, hit1;
    logic [3:0][31:0] bd0, bd1;
`endif

    entry_t q0[$];
    entry_t q1[$];
    int total = 0;
    int passed = 0;
    logic armed = 1'b0;
    vec_t tv[9];
    vec_t r;

    always #5 clk = ~clk;

    wb_queue u0 (
        .clk(clk), .reset_(reset_),
`ifdef WB_QUEUE_BYPASS_EN
        .byp_raddr(byp_raddr), .byp_hit(hit0), .byp_data(bd0),
`endif
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(rdy0),
        .waddr(wa0), .we_(we0), .wdata(wd0), .count(cnt0), .empty(emp0)
    );

    wb_queue #(.ZERO_REG(ENABLE)) u1 (
        .clk(clk), .reset_(reset_),
`ifdef WB_QUEUE_BYPASS_EN
        .byp_raddr(byp_raddr), .byp_hit(hit1), .byp_data(bd1),
`endif
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(rdy1),
        .waddr(wa1), .we_(we1), .wdata(wd1), .count(cnt1), .empty(emp1)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", n, act, exp);
    endtask

    // expected write-port view of a reference queue: oldest min(n,4) presented, youngest duplicate wins
    task automatic sb_check(input string tag, input entry_t m[$], input logic [3:0] cnt,
                            input logic emp, input logic rdy, input logic [3:0] we,
                            input logic [3:0][3:0] wa, input logic [3:0][31:0] wd);
        int n = m.size();
        int dn = n < 4 ? n : 4;
        logic e;
        chk({tag, " count"}, cnt, n);
        chk({tag, " empty"}, emp, n == 0);
        chk({tag, " in_ready"}, rdy, n <= 4);
        for (int s = 0; s < 4; s++) begin
            e = s < dn ? 1'b0 : 1'b1;
            for (int t = s + 1; t < dn; t++)
                if (m[t].addr == m[s].addr) e = 1'b1;
            chk($sformatf("%s we_[%0d]", tag, s), we[s], e);
            if (!e) begin
                chk($sformatf("%s waddr[%0d]", tag, s), wa[s], m[s].addr);
                chk($sformatf("%s wdata[%0d]", tag, s), wd[s], m[s].data);
            end
        end
    endtask

`ifdef WB_QUEUE_BYPASS_EN
    task automatic byp_check(input string tag, input entry_t m[$], input logic [3:0] hit,
                             input logic [3:0][31:0] bd);
        logic h;
        logic [31:0] dv;
        for (int k = 0; k < 4; k++) begin
            h = 1'b0;
            dv = '0;
            foreach (m[i])
                if (m[i].addr == byp_raddr[k]) begin
                    h = 1'b1;
                    dv = m[i].data;
                end
            chk($sformatf("%s byp_hit[%0d]", tag, k), hit[k], h);
            if (h) chk($sformatf("%s byp_data[%0d]", tag, k), bd[k], dv);
        end
    endtask
`endif

    task automatic model_edge(input vec_t x);
        int n0 = q0.size();
        int n1 = q1.size();
        if (!x.rst_n) begin
            q0.delete();
            q1.delete();
            return;
        end
        repeat (n0 < 4 ? n0 : 4) void'(q0.pop_front());
        repeat (n1 < 4 ? n1 : 4) void'(q1.pop_front());
        for (int i = 0; i < 4; i++) begin
            if (n0 <= 4 && x.v[i]) q0.push_back('{x.a[i], x.d[i]});
            if (n1 <= 4 && x.v[i] && x.a[i] != 4'd0) q1.push_back('{x.a[i], x.d[i]});
        end
    endtask

    task automatic cycle(input vec_t x, input int idx);
        reset_ = x.rst_n;
        in_valid = x.v;
        in_addr = x.a;
        in_data = x.d;
        @(negedge clk);
        if (armed) begin
            sb_check("u0", q0, cnt0, emp0, rdy0, we0, wa0, wd0);
            sb_check("u1", q1, cnt1, emp1, rdy1, we1, wa1, wd1);
`ifdef WB_QUEUE_BYPASS_EN
            byp_check("u0", q0, hit0, bd0);
            byp_check("u1", q1, hit1, bd1);
`endif
            if (idx >= 0) begin
                chk($sformatf("row%0d count", idx), cnt0, x.cnt);
                chk($sformatf("row%0d we_", idx), we0, x.we);
                chk($sformatf("row%0d zero-reg count", idx), cnt1, x.zcnt);
                chk($sformatf("row%0d zero-reg we_", idx), we1, x.zwe);
            end
        end
        model_edge(x);
        armed = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // expected fields describe the outputs seen while that row's inputs are applied
        tv[0] = '{1'b0, 4'b0000, '0, '0, 4'd0, 4'hf, 4'd0, 4'hf};
        tv[1] = '{1'b1, 4'b0000, '0, '0, 4'd0, 4'hf, 4'd0, 4'hf};
        tv[2] = '{1'b1, 4'b0101, {4'd0, 4'd3, 4'd0, 4'd1}, {32'd0, 32'h30, 32'd0, 32'h10},
                  4'd0, 4'hf, 4'd0, 4'hf};
        tv[3] = '{1'b1, 4'b0000, '0, '0, 4'd2, 4'b1100, 4'd2, 4'b1100};
        tv[4] = '{1'b1, 4'b0101, {4'd0, 4'd5, 4'd0, 4'd5}, {32'd0, 32'hb, 32'd0, 32'ha},
                  4'd0, 4'hf, 4'd0, 4'hf};
        tv[5] = '{1'b1, 4'b0000, '0, '0, 4'd2, 4'b1101, 4'd2, 4'b1101};
        tv[6] = '{1'b1, 4'b0001, '0, {32'd0, 32'd0, 32'd0, 32'hdeadbeef}, 4'd0, 4'hf, 4'd0, 4'hf};
        tv[7] = '{1'b1, 4'b0000, '0, '0, 4'd1, 4'b1110, 4'd0, 4'hf};
        tv[8] = '{1'b1, 4'b0000, '0, '0, 4'd0, 4'hf, 4'd0, 4'hf};
        for (int i = 0; i < 9; i++) cycle(tv[i], i);

        // back-to-back full bursts, wrapping the pointers several times
        r = tv[8];
        for (int c = 0; c < 6; c++) begin
            r.v = 4'hf;
            for (int p = 0; p < 4; p++) begin
                r.a[p] = 4'(p + 4 * c);
                r.d[p] = 32'(256 + 4 * c + p);
            end
            cycle(r, -1);
        end
        r.v = '0;
        repeat (2) cycle(r, -1);

        for (int c = 0; c < 40; c++) begin
            r.v = 4'($urandom);
            for (int p = 0; p < 4; p++) begin
                r.a[p] = 4'($urandom_range(0, 15));
                r.d[p] = $urandom;
            end
`ifdef WB_QUEUE_BYPASS_EN
            for (int p = 0; p < 4; p++) byp_raddr[p] = 4'($urandom_range(0, 15));
`endif
            cycle(r, -1);
        end

        // reset while entries are pending: nothing may be written afterwards
        r.v = 4'hf;
        r.a = {4'd4, 4'd3, 4'd2, 4'd1};
        r.d = {32'h44, 32'h33, 32'h22, 32'h11};
        cycle(r, -1);
        r.rst_n = 1'b0;
        cycle(r, -1);
        r.rst_n = 1'b1;
        r.v = '0;
        repeat (2) cycle(r, -1);

`ifdef WB_QUEUE_BYPASS_EN
        byp_raddr = {4'd0, 4'd0, 4'd7, 4'd2};
        r.v = 4'b0011;
        r.a = {4'd0, 4'd0, 4'd2, 4'd2};
        r.d = {32'd0, 32'd0, 32'h22, 32'h20};
        cycle(r, -1);
        chk("bypass hit addr 2", hit0[0], 1'b1);
        chk("bypass data addr 2", bd0[0], 32'h22);
        chk("bypass hit addr 7", hit0[1], 1'b0);
        r.v = '0;
        repeat (2) cycle(r, -1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
